// File: rtl/if_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

    localparam int          PC_STEP            = 4;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hb400001f;
    localparam logic [31:0] BUBBLE_INSTR       = 32'h0;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus: fetch drives the word address, imem returns the word.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 6
);

    logic [ADDR_W-1:0] addr;
    logic [31:0]       q;

    modport master (output addr, input q);
    modport slave  (input addr, output q);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset, hold when not enabled, sync flush to a bubble.
module if_id_reg
    import if_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         flush,
    input  logic [N-1:0] load_pc,
    input  logic [31:0]  load_instr,
    output logic [N-1:0] pc,
    output logic [31:0]  instr,
    output logic         valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            instr <= BUBBLE_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            pc    <= '0;
            instr <= BUBBLE_INSTR;
            valid <= 1'b0;
        end else if (en) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, reads imem, fills IF/ID; handles stall, redirect, halt.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int          N          = 64,
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [N-1:0]    br_target,
    if_fetch_unit_if.master imem,
    output logic [N-1:0]    pc,
    output logic [N-1:0]    pc_if_id,
    output logic [31:0]     instr_if_id,
    output logic            valid_if_id,
    output logic            halted
);

    fetch_state_t state, state_n;
    logic [N-1:0] pc_n;
    logic [N-1:0] target;
    logic         load;
    logic         flush;
    logic         unused_target_bits;

    assign target             = {br_target[N-1:2], 2'b00};
    assign unused_target_bits = ^br_target[1:0];
    assign imem.addr          = pc[ADDR_W+1:2];
    assign halted             = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
            pc    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // Redirect beats stall in every state except BOOT, which ignores both.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state)
            BOOT: begin
                flush   = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (br_taken) begin
                    pc_n  = target;
                    flush = 1'b1;
                end else if (!stall) begin
                    load = 1'b1;
                    if (imem.q == HALT_INSTR) begin
                        state_n = HALT;
                    end else begin
                        pc_n = pc + N'(PC_STEP);
                    end
                end
            end
            HALT: begin
                if (br_taken) begin
                    pc_n    = target;
                    flush   = 1'b1;
                    state_n = RUN;
                end else if (!stall) begin
                    flush = 1'b1;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    if_id_reg #(
        .N(N)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .en         (load),
        .flush      (flush),
        .load_pc    (pc),
        .load_instr (imem.q),
        .pc         (pc_if_id),
        .instr      (instr_if_id),
        .valid      (valid_if_id)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios then randomized traffic.
module tb_if_fetch_unit;

    localparam logic [31:0] HALT_W = 32'hb400001f;

    logic        clk = 1'b1;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [63:0] pc;
    logic [63:0] pc_if_id;
    logic [31:0] instr_if_id;
    logic        valid_if_id;
    logic        halted;

    logic [31:0] mem [64];

    if_fetch_unit_if #(.ADDR_W(6)) imem ();
    assign imem.q = mem[imem.addr];

    if_fetch_unit #(
        .N      (64),
        .ADDR_W (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem        (imem),
        .pc          (pc),
        .pc_if_id    (pc_if_id),
        .instr_if_id (instr_if_id),
        .valid_if_id (valid_if_id),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pid;
        logic [31:0] ins;
        logic        v;
        logic        h;
        logic [5:0]  addr;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   tests = 0;
    int   fails = 0;

    // Reference: "booting" means the next edge only inserts the start-up bubble.
    logic [63:0] m_pc = '0;
    logic [63:0] m_pid = '0;
    logic [31:0] m_ins = '0;
    bit          m_v = 0;
    bit          m_h = 0;
    bit          m_boot = 1;

    function automatic void m_reset();
        m_pc = '0; m_pid = '0; m_ins = '0;
        m_v = 0; m_h = 0; m_boot = 1;
    endfunction

    function automatic void m_bubble();
        m_pid = '0; m_ins = '0; m_v = 0;
    endfunction

    function automatic void m_edge(bit r, bit s, bit b, logic [63:0] t);
        logic [31:0] w;
        w = mem[m_pc[7:2]];
        if (r) m_reset();
        else if (m_boot) begin
            m_bubble();
            m_boot = 0;
        end else if (b) begin
            m_pc = t & ~64'd3;
            m_bubble();
            m_h = 0;
        end else if (m_h) begin
            if (!s) m_bubble();
        end else if (!s) begin
            m_pid = m_pc; m_ins = w; m_v = 1;
            if (w == HALT_W) m_h = 1;
            else m_pc = m_pc + 64'd4;
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.pc = m_pc; e.pid = m_pid; e.ins = m_ins;
        e.v = m_v; e.h = m_h; e.addr = m_pc[7:2];
        q.push_back(e);
    endfunction

    task automatic cyc(input bit r, input bit s, input bit b,
                       input logic [63:0] t);
        @(negedge clk);
        reset = r; stall = s; br_taken = b; br_target = t;
        m_edge(r, s, b, t);
        push_exp();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        m_reset();
        push_exp();
        -> chk_ev;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL no_expectation t=%0t", $time);
            end else begin
                e = q.pop_front();
                if (pc !== e.pc || pc_if_id !== e.pid || instr_if_id !== e.ins ||
                    valid_if_id !== e.v || halted !== e.h || imem.addr !== e.addr) begin
                    fails++;
                    $display("FAIL fetch_state t=%0t got pc=%h pid=%h ins=%h v=%b h=%b a=%0d req pc=%h pid=%h ins=%h v=%b h=%b a=%0d",
                             $time, pc, pc_if_id, instr_if_id, valid_if_id, halted, imem.addr,
                             e.pc, e.pid, e.ins, e.v, e.h, e.addr);
                end
            end
        end
    end

    initial begin : driver
        logic [63:0] t;
        bit r, s, b;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT_W) mem[i] = mem[i] ^ 32'h1;
        end
        mem[0]  = 32'hf8000001;
        mem[1]  = 32'hf8008002;
        mem[2]  = 32'hf8000203;
        mem[3]  = 32'h8b050083;
        mem[4]  = 32'hf8018003;
        mem[35] = 32'h8b0103e2;
        mem[46] = HALT_W;
        mem[63] = 32'h0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        // boot bubble, then words 0..3
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // misaligned redirect with simultaneous stall
        cyc(0, 1, 1, 64'h8e);
        cyc(0, 0, 0, 0);
        // halt at 0xB8 then recover
        cyc(0, 0, 1, 64'hb8);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, (i == 4), 0, 0);
        cyc(0, 0, 1, 64'h0);
        cyc(0, 0, 0, 0);
        // imem address wrap
        cyc(0, 0, 1, 64'hfc);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // async reset mid-run with pc=0x40
        cyc(0, 0, 1, 64'h3c);
        cyc(0, 0, 0, 0);
        async_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 10);
            t = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                            : 64'($urandom_range(0, 255));
            cyc(r, s, b, t);
        end
        @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover_queue got %0d entries req 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
